// File: rtl/alarm_key_entry.sv
// alarm_key_entry
//   Front-panel key-entry controller for the alarm clock. Takes one decoded
//   key per cycle from the keypad debouncer, assembles 4-digit BCD HH:MM
//   entries for the alarm or the time-of-day, validates them (00:00-23:59)
//   and commits them. SNOOZE / STOP are honoured in every state.
//
//   Optional feature (compile-time macro ALARM_KEY_TIMEOUT_EN):
//     when defined, an open entry with no key activity for TIMEOUT_CYCLES
//     cycles is abandoned exactly like CLEAR. When undefined no timeout
//     counter exists and an entry stays open indefinitely.
//
//   Ports
//     clk          system clock, all state on rising edge
//     reset        synchronous, active-high
//     key_valid    one-cycle strobe qualifying key_code
//     key_code     0-9 digit, 10 ALARM, 11 TIME, 12 SNOOZE, 13 STOP,
//                  14 ENTER, 15 CLEAR
//     alarm_time   committed alarm, BCD {ms_hr, ls_hr, ms_min, ls_min}
//     new_time     last committed time-set value, BCD
//     load_time    one-cycle pulse, new_time valid for the clock counter
//     show_alarm   high while an alarm entry is open
//     do_snooze    one-cycle pulse per SNOOZE key
//     stop_alarm   one-cycle pulse per STOP key
//     entry_busy   high while an alarm or time entry is open
//     entry_error  one-cycle pulse on a rejected ENTER
//   All outputs are registered; the response to a key appears one clock
//   after its key_valid cycle.

module alarm_key_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TO_W           = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] alarm_time,
  output logic [15:0] new_time,
  output logic        load_time,
  output logic        show_alarm,
  output logic        do_snooze,
  output logic        stop_alarm,
  output logic        entry_busy,
  output logic        entry_error
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ENTRY_ALARM = 2'd1,
    ENTRY_TIME  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    KEY_ALARM  = 4'd10,
    KEY_TIME   = 4'd11,
    KEY_SNOOZE = 4'd12,
    KEY_STOP   = 4'd13,
    KEY_ENTER  = 4'd14,
    KEY_CLEAR  = 4'd15
  } key_t;

  // The timeout counter must be able to hold TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES >= (64'd1 << TO_W)) begin : g_to_w_too_small
    $error("alarm_key_entry: TO_W too small for TIMEOUT_CYCLES");
  end

  state_t      state, state_nxt;
  logic [15:0] digit_buf, digit_buf_nxt;
  logic [2:0]  digit_cnt, digit_cnt_nxt;
  logic [15:0] alarm_time_nxt, new_time_nxt;
  logic        load_nxt, snooze_nxt, stop_nxt, error_nxt;
  logic        buf_ok;

`ifdef ALARM_KEY_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
`endif

  // HH:MM range check on the assembled buffer (digits are always 0-9).
  always_comb begin
    buf_ok = (digit_buf[15:12] <= 4'd2) && (digit_buf[11:8] <= 4'd9) &&
             (digit_buf[7:4]   <= 4'd5) && (digit_buf[3:0]  <= 4'd9) &&
             !((digit_buf[15:12] == 4'd2) && (digit_buf[11:8] > 4'd3));
  end

  always_comb begin
    state_nxt      = state;
    digit_buf_nxt  = digit_buf;
    digit_cnt_nxt  = digit_cnt;
    alarm_time_nxt = alarm_time;
    new_time_nxt   = new_time;
    load_nxt       = 1'b0;
    snooze_nxt     = 1'b0;
    stop_nxt       = 1'b0;
    error_nxt      = 1'b0;
`ifdef ALARM_KEY_TIMEOUT_EN
    to_cnt_nxt     = '0;
`endif

    if (key_valid) begin
      case (key_code)
        KEY_SNOOZE: snooze_nxt = 1'b1;
        KEY_STOP:   stop_nxt   = 1'b1;
        default: begin
          if (state == IDLE) begin
            if (key_code == KEY_ALARM || key_code == KEY_TIME) begin
              state_nxt     = (key_code == KEY_ALARM) ? ENTRY_ALARM : ENTRY_TIME;
              digit_buf_nxt = '0;
              digit_cnt_nxt = '0;
            end
          end else begin
            if (key_code <= 4'd9) begin
              if (digit_cnt != 3'd4) begin
                digit_buf_nxt = {digit_buf[11:0], key_code};
                digit_cnt_nxt = digit_cnt + 3'd1;
              end
            end else if (key_code == KEY_ENTER) begin
              if (digit_cnt == 3'd4 && buf_ok) begin
                if (state == ENTRY_ALARM) begin
                  alarm_time_nxt = digit_buf;
                end else begin
                  new_time_nxt = digit_buf;
                  load_nxt     = 1'b1;
                end
              end else begin
                error_nxt = 1'b1;
              end
              state_nxt     = IDLE;
              digit_buf_nxt = '0;
              digit_cnt_nxt = '0;
            end else if (key_code == KEY_CLEAR) begin
              state_nxt     = IDLE;
              digit_buf_nxt = '0;
              digit_cnt_nxt = '0;
            end
            // ALARM / TIME inside an entry fall through and are ignored.
          end
        end
      endcase
    end

`ifdef ALARM_KEY_TIMEOUT_EN
    // Any key restarts the count; the 0 default also covers IDLE and entry.
    if (state != IDLE && !key_valid) begin
      if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_nxt     = IDLE;
        digit_buf_nxt = '0;
        digit_cnt_nxt = '0;
      end else begin
        to_cnt_nxt = to_cnt + 1'b1;
      end
    end
`endif
  end

  // show_alarm / entry_busy are registered from the next state so that a
  // commit and the show_alarm fall land on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      digit_buf   <= '0;
      digit_cnt   <= '0;
      alarm_time  <= '0;
      new_time    <= '0;
      load_time   <= 1'b0;
      show_alarm  <= 1'b0;
      do_snooze   <= 1'b0;
      stop_alarm  <= 1'b0;
      entry_busy  <= 1'b0;
      entry_error <= 1'b0;
`ifdef ALARM_KEY_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      digit_buf   <= digit_buf_nxt;
      digit_cnt   <= digit_cnt_nxt;
      alarm_time  <= alarm_time_nxt;
      new_time    <= new_time_nxt;
      load_time   <= load_nxt;
      show_alarm  <= (state_nxt == ENTRY_ALARM);
      do_snooze   <= snooze_nxt;
      stop_alarm  <= stop_nxt;
      entry_busy  <= (state_nxt != IDLE);
      entry_error <= error_nxt;
`ifdef ALARM_KEY_TIMEOUT_EN
      to_cnt      <= to_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_alarm_key_entry.sv
// Self-checking bench for alarm_key_entry: a fixed vector table, hand-written
// corner sequences and randomized keys, all compared against a reference
// model that works on digit lists and HH/MM integer values.
module tb_alarm_key_entry;

  localparam int unsigned TB_TIMEOUT = 16;
  localparam int K_ALARM = 10, K_TIME = 11, K_SNOOZE = 12, K_STOP = 13,
                 K_ENTER = 14, K_CLEAR = 15;

  logic        clk = 1'b0;
  logic        reset, key_valid;
  logic [3:0]  key_code;
  logic [15:0] alarm_time, new_time;
  logic        load_time, show_alarm, do_snooze, stop_alarm;
  logic        entry_busy, entry_error;

  alarm_key_entry #(.TIMEOUT_CYCLES(TB_TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .alarm_time(alarm_time), .new_time(new_time), .load_time(load_time),
    .show_alarm(show_alarm), .do_snooze(do_snooze), .stop_alarm(stop_alarm),
    .entry_busy(entry_busy), .entry_error(entry_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 = idle, 1 = alarm entry, 2 = time entry.
  int m_mode;
  int m_digits[$];
  int m_alarm, m_new;
  int m_idle_run;
  bit e_load, e_err, e_snz, e_stop;

  task automatic model_step(input bit rst, input bit v, input int code);
    int hh, mm;
    e_load = 0; e_err = 0; e_snz = 0; e_stop = 0;
    if (rst) begin
      m_mode = 0; m_digits.delete(); m_alarm = 0; m_new = 0; m_idle_run = 0;
      return;
    end
    if (v) begin
      m_idle_run = 0;
      if (code == K_SNOOZE) e_snz = 1;
      else if (code == K_STOP) e_stop = 1;
      else if (m_mode == 0) begin
        if (code == K_ALARM) begin m_mode = 1; m_digits.delete(); end
        else if (code == K_TIME) begin m_mode = 2; m_digits.delete(); end
      end else if (code <= 9) begin
        if (m_digits.size() < 4) m_digits.push_back(code);
      end else if (code == K_ENTER) begin
        if (m_digits.size() == 4) begin
          hh = m_digits[0] * 10 + m_digits[1];
          mm = m_digits[2] * 10 + m_digits[3];
        end else begin
          hh = 99; mm = 99;
        end
        if (hh <= 23 && mm <= 59) begin
          if (m_mode == 1)
            m_alarm = m_digits[0]*4096 + m_digits[1]*256 + m_digits[2]*16 + m_digits[3];
          else begin
            m_new  = m_digits[0]*4096 + m_digits[1]*256 + m_digits[2]*16 + m_digits[3];
            e_load = 1;
          end
        end else e_err = 1;
        m_mode = 0;
      end else if (code == K_CLEAR) m_mode = 0;
    end else begin
`ifdef ALARM_KEY_TIMEOUT_EN
      if (m_mode != 0) begin
        m_idle_run++;
        if (m_idle_run == int'(TB_TIMEOUT)) begin m_mode = 0; m_idle_run = 0; end
      end
`endif
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit v, input int code);
    reset = rst; key_valid = v; key_code = 4'(code);
    @(posedge clk); #1;
    model_step(rst, v, code);
    check("alarm_time",  alarm_time,  16'(m_alarm));
    check("new_time",    new_time,    16'(m_new));
    check("show_alarm",  16'(show_alarm),  16'(m_mode == 1));
    check("entry_busy",  16'(entry_busy),  16'(m_mode != 0));
    check("load_time",   16'(load_time),   16'(e_load));
    check("entry_error", 16'(entry_error), 16'(e_err));
    check("do_snooze",   16'(do_snooze),   16'(e_snz));
    check("stop_alarm",  16'(stop_alarm),  16'(e_stop));
  endtask

  task automatic press(input int code);
    step(0, 1, code);
  endtask

  task automatic press_all(input int q[$]);
    foreach (q[i]) press(q[i]);
  endtask

  typedef struct {
    bit          v;
    int          code;
    logic [15:0] alarm;
    logic [15:0] nt;
    bit          show, busy, load, err, snz, stp;
  } vec_t;

  function automatic vec_t mk(bit v, int code, logic [15:0] alarm, logic [15:0] nt,
                              bit show, bit busy, bit load, bit err, bit snz, bit stp);
    vec_t r;
    r.v = v; r.code = code; r.alarm = alarm; r.nt = nt; r.show = show;
    r.busy = busy; r.load = load; r.err = err; r.snz = snz; r.stp = stp;
    return r;
  endfunction

  vec_t tbl[$];
  int   seq[$];

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 4'd0;

    // Reset, with a key asserted to show reset overrides it.
    step(1, 0, 0);
    step(1, 1, K_ALARM);
    check("reset_alarm", alarm_time, 16'h0000);
    check("reset_busy",  16'(entry_busy), 16'h0);
    check("reset_show",  16'(show_alarm), 16'h0);

    //              v  code      alarm    new      sh bs ld er sz st
    tbl.push_back(mk(1, K_ALARM,  16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,        16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 6,        16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3,        16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,        16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, K_ENTER,  16'h0630, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, K_ALARM,  16'h0630, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5,        16'h0630, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, K_ENTER,  16'h0630, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, K_CLEAR,  16'h0630, 16'h0000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, K_SNOOZE, 16'h0630, 16'h0000, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, K_TIME,   16'h0630, 16'h0000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2,        16'h0630, 16'h0000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3,        16'h0630, 16'h0000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5,        16'h0630, 16'h0000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, K_STOP,   16'h0630, 16'h0000, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 9,        16'h0630, 16'h0000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, K_ENTER,  16'h0630, 16'h2359, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,        16'h0630, 16'h2359, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(0, tbl[i].v, tbl[i].code);
      check("tbl_alarm", alarm_time, tbl[i].alarm);
      check("tbl_new",   new_time,   tbl[i].nt);
      check("tbl_flags", {10'd0, show_alarm, entry_busy, load_time, entry_error, do_snooze, stop_alarm},
            {10'd0, tbl[i].show, tbl[i].busy, tbl[i].load, tbl[i].err, tbl[i].snz, tbl[i].stp});
    end

    // 24:00 rejected, prior alarm kept.
    seq = '{K_ALARM, 2, 4, 0, 0, K_ENTER};
    press_all(seq);
    check("err_2400", 16'(entry_error), 16'h1);
    check("keep_0630", alarm_time, 16'h0630);
    // Short entry rejected.
    seq = '{K_ALARM, 1, 2, K_ENTER};
    press_all(seq);
    check("err_short", 16'(entry_error), 16'h1);
    // SNOOZE/STOP mid-entry do not disturb the digits.
    seq = '{K_ALARM, 0, 7, K_SNOOZE, 1, 5, K_STOP, K_ENTER};
    press_all(seq);
    check("alarm_0715", alarm_time, 16'h0715);
    // Fifth digit ignored; TIME inside an alarm entry ignored.
    seq = '{K_ALARM, 1, K_TIME, 2, 3, 4, 5, K_ENTER};
    press_all(seq);
    check("alarm_1234", alarm_time, 16'h1234);
    // 19:59 and 20:60 boundaries.
    seq = '{K_ALARM, 1, 9, 5, 9, K_ENTER};
    press_all(seq);
    check("alarm_1959", alarm_time, 16'h1959);
    seq = '{K_ALARM, 2, 0, 6, 0, K_ENTER};
    press_all(seq);
    check("err_2060", 16'(entry_error), 16'h1);
    // CLEAR abandons without error.
    seq = '{K_ALARM, 0, 8, K_CLEAR};
    press_all(seq);
    check("clr_err",   16'(entry_error), 16'h0);
    check("clr_busy",  16'(entry_busy),  16'h0);
    check("clr_alarm", alarm_time, 16'h1959);
    // Mid-entry reset clears committed values.
    seq = '{K_ALARM, 0, 8};
    press_all(seq);
    step(1, 0, 0);
    check("mid_rst_alarm", alarm_time, 16'h0000);
    check("mid_rst_new",   new_time,   16'h0000);
    check("mid_rst_show",  16'(show_alarm), 16'h0);

`ifdef ALARM_KEY_TIMEOUT_EN
    seq = '{K_ALARM, 0, 9};
    press_all(seq);
    for (int i = 0; i < int'(TB_TIMEOUT) - 1; i++) step(0, 0, 0);
    check("to_still_busy", 16'(entry_busy), 16'h1);
    step(0, 0, 0);
    check("to_busy_fell", 16'(entry_busy), 16'h0);
    press(K_ENTER);
    check("to_enter_err", 16'(entry_error), 16'h0);
    check("to_alarm", alarm_time, 16'h0000);
`endif

    // Randomized keys against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(299) == 0) step(1, $urandom_range(1), $urandom_range(15));
      else if ($urandom_range(49) == 0) begin
        for (int k = 0; k < 20; k++) step(0, 0, $urandom_range(15));
      end else begin
        int code;
        // Bias digits toward small values so that valid commits are common.
        code = ($urandom_range(1) == 0) ? $urandom_range(3) : $urandom_range(15);
        step(0, $urandom_range(3) != 0, code);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_key_entry.md
Name: alarm_key_entry

Overview:
- Front-panel key-entry controller for the alarm clock. Produces the control and time inputs that the display/alarm driver consumes: alarm_time, show_alarm, do_snooze and stop_alarm. It also produces a time-set load for the clock counter.
- Accepts one decoded key per cycle from the debounced keypad. Assembles 4-digit BCD HH:MM entries, validates them and commits them.
- Purely synchronous; sits between the keypad debouncer and the display driver/clock counter.

Parameters:
TIMEOUT_CYCLES, 1000, inactivity cycles before an open entry is abandoned (used only with the optional feature)
TO_W, 10, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
key_valid  in  1  one-cycle strobe; key_code valid in this cycle
key_code  in  4  0-9 digit, 10 ALARM, 11 TIME, 12 SNOOZE, 13 STOP, 14 ENTER, 15 CLEAR
alarm_time  out  16  committed alarm, BCD {ms_hr, ls_hr, ms_min, ls_min}
new_time  out  16  last committed time-set value, BCD
load_time  out  1  one-cycle pulse; new_time valid for the clock counter
show_alarm  out  1  high while in ENTRY_ALARM
do_snooze  out  1  one-cycle pulse
stop_alarm  out  1  one-cycle pulse
entry_busy  out  1  high in ENTRY_ALARM or ENTRY_TIME
entry_error  out  1  one-cycle pulse on a rejected ENTER

Behaviour:
- Reset (synchronous, active-high; overrides all other inputs):
  - state=IDLE; alarm_time=16'h0000; new_time=16'h0000; internal buffer and digit count cleared.
  - All pulse outputs are 0; show_alarm=0; entry_busy=0.
- Registering: every output is registered. Response appears one clk after the key_valid cycle. key_code is ignored when key_valid=0.
- States:
  - IDLE: ALARM -> ENTRY_ALARM; TIME -> ENTRY_TIME. Buffer cleared and count=0 on entry.
  - In IDLE, digit, ENTER and CLEAR keys are ignored.
- ENTRY_ALARM / ENTRY_TIME:
  - Digit key: buf <= {buf[11:0], key_code}, count++. When count==4, further digits are ignored; the buffer is unchanged and count saturates at 4.
  - ENTER with count==4 and a valid buffer: commit.
    - ENTRY_ALARM: alarm_time <= buf.
    - ENTRY_TIME: new_time <= buf and load_time pulses.
    - Either way, return to IDLE.
  - ENTER with count<4 or an invalid buffer: entry_error pulses; committed values are unchanged; return to IDLE.
  - CLEAR: discard the buffer, return to IDLE, no error pulse.
  - ALARM or TIME pressed while in an entry state: ignored; the current entry continues.
- Validity:
  - ms_hr<=2; ls_hr<=9; ms_min<=5; ls_min<=9.
  - If ms_hr==2 then ls_hr<=3.
  - Range 00:00-23:59.
- SNOOZE/STOP:
  - Honoured in every state so that the alarm can always be silenced.
  - Each produces a one-cycle do_snooze / stop_alarm pulse and does not change state, buffer or count.
- Pulses: exactly one cycle wide per accepted key. Holding key_valid high for N cycles with the same code yields N pulses; de-duplication is the debouncer's job.
- show_alarm=1 exactly while state==ENTRY_ALARM. The driver therefore displays alarm_time (the old committed value) during entry.
- Mid-entry reset: returns to IDLE; committed values are cleared to 0.
- Commit and display timing: a commit and its resulting show_alarm fall occur on the same edge.

Optional Feature:
ALARM_KEY_TIMEOUT_EN
- Defined:
  - A TO_W-bit counter runs in entry states. It resets to 0 on entering an entry state and on every key_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no key, the block returns to IDLE on the next edge, exactly as for CLEAR (no error pulse, no commit).
  - The counter is held at 0 in IDLE.
- Not defined: no counter is synthesised; an entry stays open indefinitely.

Test Plan:
- reset, then keys ALARM,0,6,3,0,ENTER -> show_alarm=1 from the cycle after ALARM through the ENTER cycle; alarm_time=16'h0630 the cycle after ENTER; show_alarm=0; entry_error=0.
- TIME,2,3,5,9,ENTER -> new_time=16'h2359 and load_time one-cycle pulse; alarm_time unchanged.
- ALARM,2,4,0,0,ENTER -> entry_error pulse; alarm_time keeps prior 16'h0630. Then ALARM,1,2,ENTER -> entry_error pulse (count=2).
- ALARM,0,7,SNOOZE,1,5,STOP,ENTER -> do_snooze and stop_alarm each pulse once; entry unaffected; alarm_time=16'h0715. Then ALARM,1,2,3,4,5,ENTER -> fifth digit ignored; alarm_time=16'h1234.
- ALARM,0,8,CLEAR -> IDLE, alarm_time unchanged, no error. ALARM,0,8, then reset -> alarm_time=16'h0000, state IDLE, show_alarm=0.
- With ALARM_KEY_TIMEOUT_EN, TIMEOUT_CYCLES=16: ALARM,0,9 then 16 idle cycles -> entry_busy falls, no commit; the next ENTER is ignored in IDLE.
